// File: rtl/spi_target_if.sv
// Fabric-side byte stream of the SPI target: one-deep transmit holding
// register handshake plus the receive strobe.
interface spi_target_if;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic       tx_underrun;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output tx_data, tx_load,
        input  tx_ready, tx_underrun, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_load,
        output tx_ready, tx_underrun, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 responder, MSB first, 8-bit frames. The SPI pins are oversampled
// in the clk domain; bytes are exchanged with fabric through spi_target_if.
module spi_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] TX_DEFAULT  = 8'hFF,
    parameter logic       IDLE_MISO   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          ss,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    output logic          selected,
    spi_target_if.slave   bus
);
    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_d;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall;

    state_t     state;
    logic [2:0] bit_ctr;
    logic [7:0] tx_sh, rx_sh;
    logic [7:0] hold;
    logic       hold_full;
    logic [7:0] rx_data_r;
    logic       rx_valid_r, underrun_r;
    logic       boundary;
    logic [7:0] next_byte;

    // Synchronizers reset to the pin levels of an idle, deselected bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '1;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // A byte boundary is the select edge or the fall that follows the 8th rise.
    assign boundary  = ~ss_s & ((state == S_IDLE) ||
                                (sclk_fall && bit_ctr == 3'd0));
    assign next_byte = hold_full ? hold : TX_DEFAULT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_ctr    <= 3'd0;
            tx_sh      <= TX_DEFAULT;
            rx_sh      <= 8'd0;
            hold       <= 8'd0;
            hold_full  <= 1'b0;
            rx_data_r  <= 8'd0;
            rx_valid_r <= 1'b0;
            underrun_r <= 1'b0;
            miso       <= IDLE_MISO;
            miso_oe    <= 1'b0;
            selected   <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            underrun_r <= 1'b0;

            // A boundary consumes the held byte before a same-cycle load lands.
            if (boundary && hold_full)
                hold_full <= 1'b0;
            else if (bus.tx_load && !hold_full) begin
                hold      <= bus.tx_data;
                hold_full <= 1'b1;
            end

            if (boundary) begin
                tx_sh      <= next_byte;
                miso       <= next_byte[7];
                underrun_r <= ~hold_full;
            end

            case (state)
                S_IDLE: begin
                    if (!ss_s) begin
                        state    <= S_ACTIVE;
                        selected <= 1'b1;
                        miso_oe  <= 1'b1;
                        bit_ctr  <= 3'd0;
                    end
                end
                S_ACTIVE: begin
                    if (ss_s) begin
                        state    <= S_IDLE;
                        selected <= 1'b0;
                        miso_oe  <= 1'b0;
                        miso     <= IDLE_MISO;
                        bit_ctr  <= 3'd0;
                    end else if (sclk_rise) begin
                        rx_sh   <= {rx_sh[6:0], mosi_s};
                        bit_ctr <= bit_ctr + 3'd1;
                        if (bit_ctr == 3'd7) begin
                            rx_data_r  <= {rx_sh[6:0], mosi_s};
                            rx_valid_r <= 1'b1;
                        end
                    end else if (sclk_fall && bit_ctr != 3'd0) begin
                        tx_sh <= {tx_sh[6:0], 1'b1};
                        miso  <= tx_sh[6];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_ready    = ~hold_full;
    assign bus.tx_underrun = underrun_r;
    assign bus.rx_data     = rx_data_r;
    assign bus.rx_valid    = rx_valid_r;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI master model drives the pins at
// half_period 4; received bytes are checked by a scoreboard monitor.
module tb_spi_target;
    logic clk = 1'b0;
    logic rst;
    logic sclk, ss, mosi;
    logic miso, miso_oe, selected;

    spi_target_if bus();

    spi_target dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .ss       (ss),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .selected (selected),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int under_cnt = 0;
    logic [7:0] rx_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && bus.rx_valid) begin
            if (rx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got %0h expected no rx_valid", bus.rx_data);
            end else begin
                logic [7:0] e;
                e = rx_q.pop_front();
                check("rx_data", {24'd0, bus.rx_data}, {24'd0, e});
            end
        end
    end

    always @(negedge clk)
        if (!rst && bus.tx_underrun) under_cnt++;

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic spi_begin();
        @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Leaves sclk high after the last rise; the next call or spi_end drops it.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'd0;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 1'b0;
            mosi = mo[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            mi[i] = miso;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] mo, input logic [7:0] exp_miso);
        logic [7:0] mi;
        rx_q.push_back(mo);
        spi_bits(mo, 8, mi);
        check("miso_byte", {24'd0, mi}, {24'd0, exp_miso});
    endtask

    // sclk low and ss high together: the deselect wins, no extra boundary load.
    task automatic spi_end();
        sclk = 1'b0;
        ss   = 1'b1;
        mosi = 1'b1;
        repeat (3) @(negedge clk);
        check("miso_oe_off", {31'd0, miso_oe}, 32'd0);
        check("miso_idle", {31'd0, miso}, 32'd1);
        check("deselected", {31'd0, selected}, 32'd0);
        repeat (3) @(negedge clk);
        check("rx_pending", rx_q.size(), 32'd0);
    endtask

    initial begin
        int u0;
        logic [7:0] mi;
        rst = 1'b1;
        sclk = 1'($urandom); ss = 1'($urandom); mosi = 1'($urandom);
        bus.tx_data = 8'($urandom); bus.tx_load = 1'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_miso", {31'd0, miso}, 32'd1);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_selected", {31'd0, selected}, 32'd0);
        check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check("rst_underrun", {31'd0, bus.tx_underrun}, 32'd0);
        sclk = 1'b0; ss = 1'b1; mosi = 1'b1; bus.tx_load = 1'b0; bus.tx_data = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte
        u0 = under_cnt;
        load(8'hA5);
        check("ready_after_load", {31'd0, bus.tx_ready}, 32'd0);
        spi_begin();
        check("ready_after_ss", {31'd0, bus.tx_ready}, 32'd1);
        check("selected", {31'd0, selected}, 32'd1);
        spi_xfer(8'h3C, 8'hA5);
        spi_end();
        check("single_underrun", under_cnt - u0, 32'd0);

        // Streaming two bytes, reload during the first
        u0 = under_cnt;
        load(8'h11);
        spi_begin();
        fork
            spi_xfer(8'hC3, 8'h11);
            begin
                repeat (10) @(negedge clk);
                check("stream_ready", {31'd0, bus.tx_ready}, 32'd1);
                bus.tx_data = 8'h22;
                bus.tx_load = 1'b1;
                @(negedge clk);
                bus.tx_load = 1'b0;
            end
        join
        spi_xfer(8'h5A, 8'h22);
        spi_end();
        check("stream_underrun", under_cnt - u0, 32'd0);

        // Underrun
        u0 = under_cnt;
        spi_begin();
        check("underrun_at_ss", under_cnt - u0, 32'd1);
        spi_xfer(8'h81, 8'hFF);
        spi_end();
        check("underrun_total", under_cnt - u0, 32'd1);

        // Abort after 5 rises, then a clean transfer
        u0 = under_cnt;
        spi_begin();
        spi_bits(8'hE7, 5, mi);
        spi_end();
        load(8'h5E);
        spi_begin();
        spi_xfer(8'h96, 8'h5E);
        spi_end();
        check("abort_underrun", under_cnt - u0, 32'd1);

        // Load collision: second load while full is dropped
        u0 = under_cnt;
        @(negedge clk);
        bus.tx_data = 8'h77;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_data = 8'h88;
        @(negedge clk);
        bus.tx_load = 1'b0;
        check("collision_ready", {31'd0, bus.tx_ready}, 32'd0);
        spi_begin();
        spi_xfer(8'h24, 8'h77);
        spi_end();
        check("collision_underrun", under_cnt - u0, 32'd0);
        check("collision_empty", {31'd0, bus.tx_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI responder (peripheral side) in SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- Pairs with the on-chip SPI controller, for loopback test and for exposing an internal byte stream to an external SPI master.
- Oversamples sclk/ss/mosi in the clk domain, drives miso, and exchanges bytes with fabric through a receive strobe and a one-deep transmit holding register.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on sclk, ss and mosi (minimum 2).
- TX_DEFAULT, 8'hFF: byte shifted out when no transmit byte is loaded (underrun).
- IDLE_MISO, 1'b1: miso level while not selected.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from master (asynchronous).
- ss  in  1  SPI select, active low (asynchronous).
- mosi  in  1  SPI data from master (asynchronous).
- miso  out  1  SPI data to master.
- miso_oe  out  1  tri-state enable for miso; 1 while selected.
- selected  out  1  synchronized select active.
- tx_data  in  8  byte to transmit.
- tx_load  in  1  write tx_data into the holding register.
- tx_ready  out  1  holding register empty.
- tx_underrun  out  1  1-cycle pulse: TX_DEFAULT was used for a byte.
- rx_data  out  8  last complete received byte.
- rx_valid  out  1  1-cycle pulse: rx_data updated.

Behaviour:
- Reset (rst=1 at a clk edge):
  - miso=IDLE_MISO, miso_oe=0, selected=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0.
  - Synchronizer stages load their idle values: sclk=0, ss=1, mosi=1.
  - Holding register emptied. bit_ctr=0. State S_IDLE.
  - Reset mid-transfer aborts it with no rx_valid.
- Sync: sclk, ss and mosi each pass through SYNC_STAGES flops. sclk_rise and sclk_fall are detected against one extra registered copy of synced sclk.
- Timing constraint: the SCLK high and low phases must each be ≥ SYNC_STAGES+2 clk cycles. At the defaults this means the controller's half_period is ≥ 4. Faster SCLK is unsupported and behaviour is undefined.
- States: S_IDLE, S_ACTIVE.
- S_IDLE:
  - miso=IDLE_MISO, miso_oe=0, selected=0, sclk edges ignored.
  - Synced ss=0 moves to S_ACTIVE and performs a byte-boundary load.
  - On that same edge: selected=1, miso_oe=1, bit_ctr=0.
- Byte-boundary load (uses the registered holding state):
  - Holding full: tx shift ← hold, tx_ready←1.
  - Holding empty: tx shift ← TX_DEFAULT, tx_underrun pulses.
  - miso ← new shift[7].
- S_ACTIVE, sclk_rise:
  - rx shift ← {rx shift[6:0], synced mosi}.
  - bit_ctr ← bit_ctr+1, modulo 8.
  - On the 8th rise (bit_ctr 7→0): rx_data ← completed byte and rx_valid=1 for exactly one cycle, both on the clk edge after the rise is detected.
- S_ACTIVE, sclk_fall:
  - bit_ctr≠0: tx shift ← {shift[6:0],1}, miso ← new shift[7].
  - bit_ctr=0 (byte complete): byte-boundary load for the next byte.
- Synced ss=1 while in S_ACTIVE, at any bit:
  - Return to S_IDLE on that edge; miso=IDLE_MISO, miso_oe=0.
  - Partial rx bits are discarded with no rx_valid. bit_ctr=0.
  - Holding register contents and tx_ready are kept.
- Holding register:
  - tx_load with tx_ready=1 captures tx_data; tx_ready←0 next cycle.
  - tx_load with tx_ready=0 is ignored and the held byte is unchanged.
  - tx_load in the same cycle as a boundary load that finds the holding register empty: the boundary takes TX_DEFAULT (underrun), and the loaded byte is kept for the next boundary.
  - tx_load while in S_IDLE is allowed.
- Edge ordering: sclk_rise and sclk_fall are mutually exclusive. An ss deassert takes priority over an sclk edge in the same cycle.
- Throughput: back-to-back bytes with no gap. tx_ready rises at each boundary, giving fabric a full byte time to reload.

Test Plan:
- Reset: assert rst 2 cycles with random pins -> miso=1, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0.
- Single byte: load 8'hA5, pull ss low, master (half_period 4) sends 8'h3C -> master reads 8'hA5; rx_data=8'h3C with exactly one rx_valid pulse; tx_ready=1 after the ss fall; no underrun.
- Streaming: load 8'h11, then load 8'h22 mid-byte once tx_ready=1, 2 bytes, master sends 8'hC3,8'h5A -> master reads 8'h11,8'h22; rx_valid pulses twice with 8'hC3, 8'h5A.
- Underrun: nothing loaded, 1 byte -> master reads 8'hFF; tx_underrun pulses once at the ss fall.
- Abort: ss high after 5 rises -> no rx_valid; miso_oe=0 within SYNC_STAGES+1 cycles. Next transaction with 8'h96 is received correctly, bit-aligned.
- Load collision: tx_load 8'h77 then 8'h88 on consecutive cycles with tx_ready=0 after the first -> the next byte shifted out is 8'h77; 8'h88 is dropped.
